// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel MUX scan controller.
package mux_scan_pkg;

  localparam int NUM_CHANNELS = 4;
  localparam int SELECT_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_e;

  // Index of the lowest set bit; callers guarantee the mask is non-zero.
  function automatic logic [SELECT_WIDTH-1:0] first_channel(input logic [NUM_CHANNELS-1:0] mask);
    first_channel = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) first_channel = SELECT_WIDTH'(i);
    end
  endfunction

endpackage

// File: rtl/mux_scan_next_channel.sv
// Combinational search for the next enabled channel above the current index.
module mux_scan_next_channel
  import mux_scan_pkg::*;
(
  input  logic [NUM_CHANNELS-1:0] mask_i,
  input  logic [SELECT_WIDTH-1:0] index_i,
  output logic [SELECT_WIDTH-1:0] next_o,
  output logic                    found_o
);

  // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(index_i))) begin
        next_o  = SELECT_WIDTH'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_controller.sv
// Scans the enabled inputs of a downstream 4:1 MUX, dwelling on each channel
// before sampling, and publishes the completed frame with a one-cycle valid pulse.
module mux_scan_controller
  import mux_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic                    Clock_In,
  input  logic                    Reset_In,
  input  logic                    Start_In,
  input  logic                    Continuous_In,
  input  logic [NUM_CHANNELS-1:0] Channel_Mask_In,
  input  logic                    MUX_Data_In,
  output logic [SELECT_WIDTH-1:0] Select_Out,
  output logic                    MUX_Enable_Out,
  output logic [NUM_CHANNELS-1:0] Frame_Out,
  output logic                    Frame_Valid_Out,
  output logic                    Busy_Out
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_e                  state_q;
  logic [SELECT_WIDTH-1:0] sel_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_CHANNELS-1:0] mask_q;
  logic [NUM_CHANNELS-1:0] shadow_q;
  logic [NUM_CHANNELS-1:0] shadow_d;
  logic [NUM_CHANNELS-1:0] frame_q;
  logic                    valid_q;
  logic                    enable_q;
  logic                    busy_q;
  logic [SELECT_WIDTH-1:0] next_sel;
  logic                    next_found;
  logic                    launch;

  mux_scan_next_channel u_next_channel (
    .mask_i  (mask_q),
    .index_i (sel_q),
    .next_o  (next_sel),
    .found_o (next_found)
  );

  always_comb begin
    shadow_d        = shadow_q;
    shadow_d[sel_q] = MUX_Data_In;
  end

  // A frame begins from IDLE on Start_In, or back-to-back from DONE in continuous mode.
  assign launch = (((state_q == IDLE) && Start_In) || ((state_q == DONE) && Continuous_In))
                  && (Channel_Mask_In != '0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (launch) begin
        mask_q   <= Channel_Mask_In;
        shadow_q <= '0;
        sel_q    <= first_channel(Channel_Mask_In);
        cnt_q    <= '0;
        state_q  <= SETTLE;
        enable_q <= 1'b1;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          SETTLE: begin
            if (cnt_q == CNT_LAST) begin
              shadow_q <= shadow_d;
              cnt_q    <= '0;
              if (next_found) begin
                sel_q <= next_sel;
              end else begin
                frame_q  <= shadow_d;
                valid_q  <= 1'b1;
                enable_q <= 1'b0;
                state_q  <= DONE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign Select_Out      = sel_q;
  assign MUX_Enable_Out  = enable_q;
  assign Frame_Out       = frame_q;
  assign Frame_Valid_Out = valid_q;
  assign Busy_Out        = busy_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Self-checking bench: a frame-schedule reference model predicts every output each cycle.
module tb_mux_scan_controller;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       Reset_In;
  logic       Start_In;
  logic       Continuous_In;
  logic [3:0] Channel_Mask_In;
  logic       MUX_Data_In;
  logic [1:0] Select_Out;
  logic       MUX_Enable_Out;
  logic [3:0] Frame_Out;
  logic       Frame_Valid_Out;
  logic       Busy_Out;

  logic [3:0] chan_data;
  logic [3:0] fixed_data;
  bit         fixed_en;

  always #5 clk = ~clk;

  // Downstream 4:1 MUX: returns whichever channel the DUT currently selects.
  assign MUX_Data_In = chan_data[Select_Out];

  mux_scan_controller #(.DWELL_CYCLES(DW)) dut (
    .Clock_In        (clk),
    .Reset_In        (Reset_In),
    .Start_In        (Start_In),
    .Continuous_In   (Continuous_In),
    .Channel_Mask_In (Channel_Mask_In),
    .MUX_Data_In     (MUX_Data_In),
    .Select_Out      (Select_Out),
    .MUX_Enable_Out  (MUX_Enable_Out),
    .Frame_Out       (Frame_Out),
    .Frame_Valid_Out (Frame_Valid_Out),
    .Busy_Out        (Busy_Out)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;
  int valid_cnt = 0;
  int last_valid = -1;

  // Reference model: a frame is a list of channels plus the cycle its start was sampled.
  bit         m_active = 0;
  int         m_start = 0;
  int         m_chans[$];
  int         m_k = 0;
  logic [3:0] m_shadow = '0;
  logic [3:0] m_frame = '0;
  logic [1:0] m_sel = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  task automatic start_frame(input logic [3:0] mk);
    m_active = 1;
    m_start  = n;
    m_shadow = '0;
    m_chans.delete();
    for (int i = 0; i < 4; i++) if (mk[i]) m_chans.push_back(i);
    m_k   = m_chans.size();
    m_sel = 2'(m_chans[0]);
  endtask

  task automatic model_reset();
    m_active = 0;
    m_shadow = '0;
    m_frame  = '0;
    m_sel    = '0;
  endtask

  // One cycle: compare against the model, drive new inputs, advance the model.
  task automatic run_cycle(input logic st, input logic co, input logic [3:0] mk);
    int off;
    logic [1:0] e_sel;
    logic e_busy, e_en, e_val;
    @(negedge clk);
    n++;
    off    = 0;
    e_sel  = m_sel;
    e_busy = 0;
    e_en   = 0;
    e_val  = 0;
    if (m_active) begin
      off    = n - m_start - 1;
      e_busy = 1;
      if (off < m_k * DW) begin
        e_en  = 1;
        e_sel = 2'(m_chans[off / DW]);
      end else begin
        e_val   = 1;
        e_sel   = 2'(m_chans[m_k - 1]);
        m_frame = m_shadow;
      end
    end
    check("busy", 32'(Busy_Out), 32'(e_busy));
    check("enable", 32'(MUX_Enable_Out), 32'(e_en));
    check("valid", 32'(Frame_Valid_Out), 32'(e_val));
    check("select", 32'(Select_Out), 32'(e_sel));
    check("frame", 32'(Frame_Out), 32'(m_frame));
    if (Frame_Valid_Out === 1'b1) begin
      valid_cnt++;
      last_valid = n;
    end

    Start_In        = st;
    Continuous_In   = co;
    Channel_Mask_In = mk;
    chan_data       = fixed_en ? fixed_data : 4'($urandom);

    if (!m_active) begin
      if (st && mk != 0) start_frame(mk);
    end else if (off < m_k * DW) begin
      m_sel = e_sel;
      if (off % DW == DW - 1) m_shadow[e_sel] = chan_data[e_sel];
    end else begin
      m_sel = e_sel;
      if (co && mk != 0) start_frame(mk);
      else m_active = 0;
    end
  endtask

  task automatic idle_cycles(input int cnt, input logic [3:0] mk);
    for (int i = 0; i < cnt; i++) run_cycle(1'b0, 1'b0, mk);
  endtask

  // Reset asserted mid-cycle, away from either clock edge.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2;
    Reset_In = 1'b1;
    Start_In = 1'b0;
    Continuous_In = 1'b0;
    #1;
    check({tag, "_sel"}, 32'(Select_Out), 32'd0);
    check({tag, "_en"}, 32'(MUX_Enable_Out), 32'd0);
    check({tag, "_frame"}, 32'(Frame_Out), 32'd0);
    check({tag, "_valid"}, 32'(Frame_Valid_Out), 32'd0);
    check({tag, "_busy"}, 32'(Busy_Out), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    Reset_In = 1'b0;
  endtask

  initial begin
    int s;
    logic co;
    Reset_In        = 1'b1;
    Start_In        = 1'b0;
    Continuous_In   = 1'b0;
    Channel_Mask_In = '0;
    chan_data       = '0;
    fixed_data      = '0;
    fixed_en        = 0;
    #3;
    check("por_busy", 32'(Busy_Out), 32'd0);
    check("por_frame", 32'(Frame_Out), 32'd0);
    check("por_sel", 32'(Select_Out), 32'd0);
    @(posedge clk);
    #2;
    Reset_In = 1'b0;
    idle_cycles(3, 4'hF);

    // Full mask, channels 0..3 driving 1,0,1,1.
    fixed_en = 1;
    fixed_data = 4'b1101;
    valid_cnt = 0;
    run_cycle(1'b1, 1'b0, 4'b1111);
    s = n;
    idle_cycles(20, 4'b1111);
    check("full_pulses", 32'(valid_cnt), 32'd1);
    check("full_latency", 32'(last_valid - s), 32'd17);
    check("full_frame", 32'(Frame_Out), 32'b1101);

    // Sparse mask, all channels driving 1.
    fixed_data = 4'b1111;
    valid_cnt = 0;
    run_cycle(1'b1, 1'b0, 4'b1010);
    s = n;
    idle_cycles(12, 4'b1010);
    check("sparse_pulses", 32'(valid_cnt), 32'd1);
    check("sparse_latency", 32'(last_valid - s), 32'd9);
    check("sparse_frame", 32'(Frame_Out), 32'b1010);
    fixed_en = 0;

    // Continuous on a single channel, then dropped mid-frame.
    valid_cnt = 0;
    run_cycle(1'b1, 1'b1, 4'b0001);
    s = n;
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b1, 4'b0001);
    check("cont_pulses_running", 32'(valid_cnt), 32'd2);
    check("cont_period", 32'(last_valid - s), 32'd10);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 4'b0001);
    check("cont_pulses_total", 32'(valid_cnt), 32'd3);
    check("cont_last", 32'(last_valid - s), 32'd15);
    check("cont_idle_busy", 32'(Busy_Out), 32'd0);

    // Reset in cycle 6 of a full-mask frame discards the partial frame.
    valid_cnt = 0;
    run_cycle(1'b1, 1'b0, 4'b1111);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 4'b1111);
    pulse_reset("midrst");
    idle_cycles(20, 4'b1111);
    check("midrst_pulses", 32'(valid_cnt), 32'd0);

    // Start re-pulsed and mask changed while busy: the latched mask still rules.
    valid_cnt = 0;
    run_cycle(1'b1, 1'b0, 4'b1111);
    s = n;
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 4'b0001);
    idle_cycles(12, 4'b0001);
    check("busyign_pulses", 32'(valid_cnt), 32'd1);
    check("busyign_latency", 32'(last_valid - s), 32'd17);

    // Start with an empty mask is ignored.
    valid_cnt = 0;
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, 4'b0000);
    check("empty_pulses", 32'(valid_cnt), 32'd0);
    check("empty_busy", 32'(Busy_Out), 32'd0);
    check("empty_en", 32'(MUX_Enable_Out), 32'd0);
    idle_cycles(2, 4'b0000);

    // Randomized traffic against the model.
    co = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) co = ~co;
      run_cycle(($urandom_range(0, 3) == 0), co, 4'($urandom));
      if (i == 300) pulse_reset("rndrst");
    end
    idle_cycles(25, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
